// File: rtl/image_store_arbiter.sv
// Packet-granular 2:1 Avalon-ST arbiter with a single registered output stage and channel tag.
// Optional build macro IMAGE_STORE_ARB_FIXED_PRI_EN selects fixed priority (source 0) instead of round-robin.
module image_store_arbiter #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_0_data,
  input  logic                  din_0_valid,
  output logic                  din_0_ready,
  input  logic                  din_0_startofpacket,
  input  logic                  din_0_endofpacket,
  input  logic [DATA_WIDTH-1:0] din_1_data,
  input  logic                  din_1_valid,
  output logic                  din_1_ready,
  input  logic                  din_1_startofpacket,
  input  logic                  din_1_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  dout_channel
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                state_reg;
  logic                  out_free;
  logic                  sel;
  logic                  beat_accept;
  logic [1:0]            granted;
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0]            in_valid;
  logic [1:0]            in_sop;
  logic [1:0]            in_eop;
  logic [1:0]            in_ready;
  logic [1:0]            in_accept;

  assign in_data[0] = din_0_data;
  assign in_data[1] = din_1_data;
  assign in_valid   = {din_1_valid, din_0_valid};
  assign in_sop     = {din_1_startofpacket, din_0_startofpacket};
  assign in_eop     = {din_1_endofpacket, din_0_endofpacket};
  assign granted    = {state_reg == GRANT1, state_reg == GRANT0};

  assign out_free    = !dout_valid | dout_ready;
  assign sel         = (state_reg == GRANT1);
  assign beat_accept = |in_accept;

  // Ready depends only on state and downstream ready, never on din valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign in_ready[gi]  = granted[gi] & out_free;
      assign in_accept[gi] = in_valid[gi] & in_ready[gi];
    end
  endgenerate

  assign din_0_ready = in_ready[0];
  assign din_1_ready = in_ready[1];

`ifndef IMAGE_STORE_ARB_FIXED_PRI_EN
  // Remembers the source of the most recently completed packet for round-robin ties.
  logic last_grant_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (in_accept[0] & in_eop[0]) begin
      last_grant_reg <= 1'b0;
    end else if (in_accept[1] & in_eop[1]) begin
      last_grant_reg <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      dout_data          <= '0;
      dout_valid         <= 1'b0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      dout_channel       <= 1'b0;
    end else begin
      if (out_free) begin
        if (beat_accept) begin
          dout_data          <= in_data[sel];
          dout_valid         <= 1'b1;
          dout_startofpacket <= in_sop[sel];
          dout_endofpacket   <= in_eop[sel];
          dout_channel       <= sel;
        end else begin
          dout_valid <= 1'b0;
        end
      end

      // The grant is held for a whole packet; only an accepted EOP releases it.
      case (state_reg)
        IDLE: begin
          if (in_valid[0] & in_valid[1]) begin
`ifdef IMAGE_STORE_ARB_FIXED_PRI_EN
            state_reg <= GRANT0;
`else
            state_reg <= last_grant_reg ? GRANT0 : GRANT1;
`endif
          end else if (in_valid[0]) begin
            state_reg <= GRANT0;
          end else if (in_valid[1]) begin
            state_reg <= GRANT1;
          end
        end
        GRANT0: begin
          if (in_accept[0] & in_eop[0]) state_reg <= IDLE;
        end
        GRANT1: begin
          if (in_accept[1] & in_eop[1]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_store_arbiter.sv
// Directed self-checking bench for image_store_arbiter; one task per scenario.
// Honours IMAGE_STORE_ARB_FIXED_PRI_EN for the expected grant order.
module tb_image_store_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] din_0_data, din_1_data, dout_data;
  logic       din_0_valid, din_0_ready, din_0_startofpacket, din_0_endofpacket;
  logic       din_1_valid, din_1_ready, din_1_startofpacket, din_1_endofpacket;
  logic       dout_valid, dout_ready, dout_startofpacket, dout_endofpacket, dout_channel;

  int checks;
  int failures;

  // Simple packet sources: pkts packets of len beats, data = base + beat index.
  int       src_pkts [2];
  int       src_len  [2];
  int       src_idx  [2];
  logic [9:0] src_base [2];
  bit       src_en   [2];

  image_store_arbiter #(.DATA_WIDTH(10)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .din_0_data          (din_0_data),
    .din_0_valid         (din_0_valid),
    .din_0_ready         (din_0_ready),
    .din_0_startofpacket (din_0_startofpacket),
    .din_0_endofpacket   (din_0_endofpacket),
    .din_1_data          (din_1_data),
    .din_1_valid         (din_1_valid),
    .din_1_ready         (din_1_ready),
    .din_1_startofpacket (din_1_startofpacket),
    .din_1_endofpacket   (din_1_endofpacket),
    .dout_data           (dout_data),
    .dout_valid          (dout_valid),
    .dout_ready          (dout_ready),
    .dout_startofpacket  (dout_startofpacket),
    .dout_endofpacket    (dout_endofpacket),
    .dout_channel        (dout_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_sources();
    din_0_valid         = src_en[0] && (src_pkts[0] > 0);
    din_0_data          = src_base[0] + 10'(src_idx[0]);
    din_0_startofpacket = (src_idx[0] == 0);
    din_0_endofpacket   = (src_idx[0] == src_len[0] - 1);
    din_1_valid         = src_en[1] && (src_pkts[1] > 0);
    din_1_data          = src_base[1] + 10'(src_idx[1]);
    din_1_startofpacket = (src_idx[1] == 0);
    din_1_endofpacket   = (src_idx[1] == src_len[1] - 1);
  endtask

  task automatic set_src(input int s, input int pkts, input int len, input logic [9:0] base);
    src_pkts[s] = pkts;
    src_len[s]  = len;
    src_idx[s]  = 0;
    src_base[s] = base;
    src_en[s]   = 1'b1;
  endtask

  // Advance one clock; sources step to their next beat when accepted at this edge.
  task automatic cycle();
    logic a0, a1;
    #1;
    a0 = din_0_valid & din_0_ready;
    a1 = din_1_valid & din_1_ready;
    @(posedge clk);
    #1;
    if (a0) begin
      src_idx[0]++;
      if (src_idx[0] == src_len[0]) begin src_idx[0] = 0; src_pkts[0]--; end
    end
    if (a1) begin
      src_idx[1]++;
      if (src_idx[1] == src_len[1]) begin src_idx[1] = 0; src_pkts[1]--; end
    end
    drive_sources();
    if (dout_valid)
      $display("t=%0t beat ch=%0d data=%h sop=%0b eop=%0b", $time, dout_channel, dout_data,
               dout_startofpacket, dout_endofpacket);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dout_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      src_pkts[s] = 0; src_len[s] = 1; src_idx[s] = 0; src_base[s] = '0; src_en[s] = 1'b1;
    end
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dout_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      src_pkts[s] = 0; src_len[s] = 1; src_idx[s] = 0; src_base[s] = '0; src_en[s] = 1'b1;
    end
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 10'h0 || dout_startofpacket !== 1'b0 ||
        dout_endofpacket !== 1'b0 || dout_channel !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b c=%b required all 0",
               dout_valid, dout_data, dout_startofpacket, dout_endofpacket, dout_channel);
    end
    checks++;
    if (din_0_ready !== 1'b0 || din_1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got r0=%b r1=%b required 0 0", din_0_ready, din_1_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    do_reset();
    set_src(0, 1, 4, 10'd1);
    drive_sources();
    cycle();
    checks++;
    if (dout_valid !== 1'b0 || din_0_ready !== 1'b1 || din_1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: got v=%b r0=%b r1=%b required 0 1 0", dout_valid, din_0_ready, din_1_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== 10'(i) || dout_startofpacket !== (i == 1) ||
          dout_endofpacket !== (i == 4) || dout_channel !== 1'b0 || din_1_ready !== 1'b0) begin
        failures++;
        $display("FAIL single_beat%0d: got v=%b d=%h s=%b e=%b c=%b r1=%b required 1 %h %b %b 0 0",
                 i, dout_valid, dout_data, dout_startofpacket, dout_endofpacket, dout_channel,
                 din_1_ready, 10'(i), (i == 1), (i == 4));
      end
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after: got v=%b required 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    int p, b;
    logic ch;
    do_reset();
    set_src(0, 2, 3, 10'h10);
    set_src(1, 2, 3, 10'h20);
    drive_sources();
    // Each packet: one grant cycle then three beats, so dout is idle every fourth cycle.
    for (int k = 1; k <= 17; k++) begin
      cycle();
      if ((k % 4 != 1) && (k <= 16)) begin
        p = (k - 2) / 4;
        b = (k - 2) % 4;
`ifdef IMAGE_STORE_ARB_FIXED_PRI_EN
        ch = (p >= 2);
`else
        ch = p[0];
`endif
        checks++;
        if (dout_valid !== 1'b1 || dout_channel !== ch ||
            dout_data !== ((ch ? 10'h20 : 10'h10) + 10'(b)) ||
            dout_startofpacket !== (b == 0) || dout_endofpacket !== (b == 2)) begin
          failures++;
          $display("FAIL rr_cycle%0d: got v=%b c=%b d=%h s=%b e=%b required 1 %b %h %b %b",
                   k, dout_valid, dout_channel, dout_data, dout_startofpacket, dout_endofpacket,
                   ch, (ch ? 10'h20 : 10'h10) + 10'(b), (b == 0), (b == 2));
        end
      end else begin
        checks++;
        if (dout_valid !== 1'b0) begin
          failures++;
          $display("FAIL rr_gap%0d: got v=%b required 0", k, dout_valid);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_src(0, 1, 4, 10'h30);
    drive_sources();
    repeat (3) cycle();
    dout_ready = 1'b0;
    #1;
    checks++;
    if (din_0_ready !== 1'b0 || dout_data !== 10'h31) begin
      failures++;
      $display("FAIL stall_enter: got r0=%b d=%h required 0 031", din_0_ready, dout_data);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== 10'h31 || dout_startofpacket !== 1'b0 ||
          dout_endofpacket !== 1'b0 || dout_channel !== 1'b0 || din_0_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b d=%h s=%b e=%b c=%b r0=%b required 1 031 0 0 0 0",
                 i, dout_valid, dout_data, dout_startofpacket, dout_endofpacket, dout_channel, din_0_ready);
      end
    end
    dout_ready = 1'b1;
    cycle();
    checks++;
    if (dout_valid !== 1'b1 || dout_data !== 10'h32 || dout_endofpacket !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got v=%b d=%h e=%b required 1 032 0", dout_valid, dout_data, dout_endofpacket);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b1 || dout_data !== 10'h33 || dout_endofpacket !== 1'b1) begin
      failures++;
      $display("FAIL stall_last: got v=%b d=%h e=%b required 1 033 1", dout_valid, dout_data, dout_endofpacket);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_after: got v=%b required 0", dout_valid);
    end
  endtask

  task automatic test_valid_drop();
    do_reset();
    set_src(0, 1, 4, 10'h40);
    set_src(1, 1, 1, 10'h50);
    drive_sources();
    repeat (3) cycle();
    checks++;
    if (dout_data !== 10'h41 || dout_channel !== 1'b0) begin
      failures++;
      $display("FAIL drop_prefix: got d=%h c=%b required 041 0", dout_data, dout_channel);
    end
    src_en[0] = 1'b0;
    drive_sources();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (din_1_ready !== 1'b0 || din_0_ready !== 1'b1 || dout_valid !== 1'b0) begin
        failures++;
        $display("FAIL drop_hold%0d: got r1=%b r0=%b v=%b required 0 1 0", i, din_1_ready, din_0_ready, dout_valid);
      end
    end
    src_en[0] = 1'b1;
    drive_sources();
    cycle();
    cycle();
    checks++;
    if (dout_data !== 10'h43 || dout_endofpacket !== 1'b1 || dout_channel !== 1'b0 || din_1_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_eop: got d=%h e=%b c=%b r1=%b required 043 1 0 0",
               dout_data, dout_endofpacket, dout_channel, din_1_ready);
    end
    cycle();
    checks++;
    if (din_1_ready !== 1'b1 || din_0_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_regrant: got r1=%b r0=%b required 1 0", din_1_ready, din_0_ready);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b1 || dout_data !== 10'h50 || dout_channel !== 1'b1) begin
      failures++;
      $display("FAIL drop_src1: got v=%b d=%h c=%b required 1 050 1", dout_valid, dout_data, dout_channel);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    set_src(1, 1, 1, 10'h3FF);
    drive_sources();
    cycle();
    checks++;
    if (din_1_ready !== 1'b1 || din_0_ready !== 1'b0) begin
      failures++;
      $display("FAIL onebeat_grant: got r1=%b r0=%b required 1 0", din_1_ready, din_0_ready);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b1 || dout_data !== 10'h3FF || dout_channel !== 1'b1 ||
        dout_startofpacket !== 1'b1 || dout_endofpacket !== 1'b1 || din_1_ready !== 1'b0) begin
      failures++;
      $display("FAIL onebeat_out: got v=%b d=%h c=%b s=%b e=%b r1=%b required 1 3ff 1 1 1 0",
               dout_valid, dout_data, dout_channel, dout_startofpacket, dout_endofpacket, din_1_ready);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL onebeat_after: got v=%b required 0", dout_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_src(0, 1, 4, 10'h60);
    drive_sources();
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 10'h0 || dout_startofpacket !== 1'b0 ||
        dout_endofpacket !== 1'b0 || dout_channel !== 1'b0 || din_0_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got v=%b d=%h s=%b e=%b c=%b r0=%b required all 0",
               dout_valid, dout_data, dout_startofpacket, dout_endofpacket, dout_channel, din_0_ready);
    end
    set_src(0, 1, 1, 10'h70);
    set_src(1, 1, 1, 10'h71);
    drive_sources();
    #1;
    rst = 1'b0;
    cycle();
    checks++;
    if (din_0_ready !== 1'b1 || din_1_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_tie: got r0=%b r1=%b required 1 0", din_0_ready, din_1_ready);
    end
    cycle();
    checks++;
    if (dout_valid !== 1'b1 || dout_data !== 10'h70 || dout_channel !== 1'b0) begin
      failures++;
      $display("FAIL midreset_first: got v=%b d=%h c=%b required 1 070 0", dout_valid, dout_data, dout_channel);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    dout_ready = 1'b1;
    test_reset();
    test_single_source();
    test_back_to_back();
    test_stall();
    test_valid_drop();
    test_single_beat();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_store_arbiter.md
Name: image_store_arbiter

Overview:
- Packet-granular 2:1 arbiter for Avalon-ST video streams; shares one downstream sink, e.g. the frame-store writer or a stream splitter input, between two image sources.
- Grants one source for a whole packet (SOP..EOP), never interleaves beats, and alternates round-robin when both sources request.
- Output is a single registered stage, with a channel tag identifying the source of each beat.

Parameters:
DATA_WIDTH, 10, width of every data bus

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
din_0_data  in  DATA_WIDTH  source 0 beat data
din_0_valid  in  1  source 0 beat valid
din_0_ready  out  1  source 0 beat accepted when valid&ready
din_0_startofpacket  in  1  source 0 first beat of packet
din_0_endofpacket  in  1  source 0 last beat of packet
din_1_data/valid/ready/startofpacket/endofpacket: same as din_0_*, for source 1
dout_data  out  DATA_WIDTH  registered beat data
dout_valid  out  1  registered beat valid
dout_ready  in  1  downstream ready
dout_startofpacket  out  1  registered SOP
dout_endofpacket  out  1  registered EOP
dout_channel  out  1  source index of current dout beat

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - dout_valid, dout_startofpacket, dout_endofpacket and dout_channel = 0; dout_data = 0.
  - State = IDLE; last_grant = 1, so source 0 wins the first tie.
- Output stage: out_free = !dout_valid | dout_ready. The dout_* registers load only when out_free.
  - If out_free and no beat is accepted that cycle, dout_valid <= 0.
  - dout_* holds stable while dout_valid & !dout_ready.
- Ready:
  - din_x_ready = (state == GRANTx) & out_free.
  - Both ready outputs are 0 in IDLE and for the non-granted source.
  - Ready is combinational from dout_ready; no combinational path from din_valid to din_ready.
- Latency: a beat accepted on input at cycle N is presented on dout at cycle N+1. Zero-bubble throughput within a packet when dout_ready stays high.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE with only din_0_valid: GRANT0. With only din_1_valid: GRANT1. With neither: stay IDLE.
  - IDLE with both valid: grant the source != last_grant.
  - GRANTx, accepted beat with din_x_endofpacket = 1: go to IDLE and set last_grant <= x.
  - GRANTx otherwise: stay.
- Packet gap: one arbitration cycle (IDLE) between consecutive packets, including back-to-back packets from the same source.
- SOP is not checked: the first beat after a grant is forwarded as-is. A beat that has both SOP and EOP is a one-beat packet, and the grant is released after it.
- A valid drop or stall on the granted source mid-packet keeps the grant; the other source waits indefinitely (no timeout).
- dout_channel is registered with the beat, equal to the granted index.
- Reset mid-packet: immediate return to the reset state. The downstream sees a truncated packet; no recovery logic is included.

Optional Feature:
- Macro: IMAGE_STORE_ARB_FIXED_PRI_EN.
- Defined: fixed priority. In IDLE with both valid, source 0 is always granted; last_grant is unused (may be removed).
- Undefined: round-robin as specified above.
- Packet locking, latency and ports are identical in both builds.

Test Plan:
- Only din_0 sends a 4-beat packet (data 1,2,3,4; SOP on beat 1, EOP on beat 4), dout_ready = 1 -> dout shows 1..4 on consecutive cycles, starting 2 cycles after din_0_valid rises; SOP/EOP aligned; dout_channel = 0; din_1_ready = 0 throughout.
- Both sources hold 3-beat packets continuously valid -> order after reset is 0,1,0,1; one IDLE cycle between packets; no interleaving. With IMAGE_STORE_ARB_FIXED_PRI_EN defined -> 0,0,0 while din_0 keeps requesting.
- dout_ready = 0 for 5 cycles mid-packet -> dout_data/SOP/EOP/channel stable; din_0_ready = 0; no beat lost or duplicated after release.
- din_1 requests while din_0 is mid-packet and has deasserted valid for 3 cycles -> grant stays 0; din_1_ready = 0 until the din_0 EOP beat is accepted.
- Single-beat packet (SOP = EOP = 1, data 0x3FF) on din_1 -> one dout beat 0x3FF with channel 1; FSM back to IDLE on the next cycle.
- Assert rst during beat 2 of 4 -> all dout_* = 0 asynchronously; after release, din_0 is granted first on a tie.
